// File: rtl/eth_tx_arbiter.sv
// Frame-atomic round-robin arbiter that shares one byte-serial Ethernet TX path
// between an ARP/ICMP reply source (port 0) and a UDP payload source (port 1).
module eth_tx_arbiter #(
   parameter int IFG_CYCLES      = 48,
   parameter int TIMEOUT_CYCLES  = 256,
   parameter int MAX_FRAME_BYTES = 1526
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] req0_byte,
   input  logic       req0_valid,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic [7:0] req1_byte,
   input  logic       req1_valid,
   input  logic       req1_last,
   output logic       req1_ready,
   output logic [7:0] tx_byte,
   output logic       tx_valid,
   output logic       tx_last,
   input  logic       tx_ready,
   output logic       tx_abort,
   output logic [1:0] grant
);

   localparam int IFG_W   = $clog2(IFG_CYCLES);
   localparam int STALL_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [IFG_W-1:0]   IFG_LAST   = IFG_W'(IFG_CYCLES - 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
   localparam logic [10:0]        BYTE_MAX   = 11'(MAX_FRAME_BYTES);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_IFG   = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [1:0]         grant_r;
   logic [1:0]         grant_pick_s;
   logic               last_served_r;
   logic [10:0]        byte_cnt_r;
   logic [IFG_W-1:0]   ifg_cnt_r;
   logic [STALL_W-1:0] stall_cnt_r;

   logic               sel_s;
   logic [7:0]         g_byte_s;
   logic               g_valid_s;
   logic               g_last_s;
   logic               hs_s;
   logic               oversize_s;
   logic               stall_to_s;
   logic               state_change_s;

   assign grant = grant_r;

   // Select the granted source's byte stream (grant is one-hot, bit 1 = port 1).
   always_comb begin
      sel_s = grant_r[1];
      if (sel_s) begin
         g_byte_s  = req1_byte;
         g_valid_s = req1_valid;
         g_last_s  = req1_last;
      end else begin
         g_byte_s  = req0_byte;
         g_valid_s = req0_valid;
         g_last_s  = req0_last;
      end
   end

   // Arbitration choice; a tie goes to the source that was not served last.
   always_comb begin
      grant_pick_s = 2'b00;
      if (req0_valid && req1_valid) begin
         if (last_served_r) begin
            grant_pick_s = 2'b01;
         end else begin
            grant_pick_s = 2'b10;
         end
      end else if (req0_valid) begin
         grant_pick_s = 2'b01;
      end else if (req1_valid) begin
         grant_pick_s = 2'b10;
      end else begin
         grant_pick_s = 2'b00;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_nxt_s = state_r;
      tx_byte     = 8'h00;
      tx_valid    = 1'b0;
      tx_last     = 1'b0;
      tx_abort    = 1'b0;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      hs_s        = 1'b0;
      oversize_s  = 1'b0;
      stall_to_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (grant_pick_s != 2'b00) begin
               state_nxt_s = ST_GRANT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_GRANT: begin
            // Watchdog only advances while the transmitter could take a byte.
            oversize_s = (byte_cnt_r == BYTE_MAX) && !g_last_s;
            hs_s       = g_valid_s && tx_ready;
            stall_to_s = !g_valid_s && tx_ready && (stall_cnt_r == STALL_LAST);
            tx_byte    = g_byte_s;
            tx_valid   = g_valid_s && !oversize_s;
            tx_last    = g_last_s;
            req0_ready = !sel_s && tx_ready;
            req1_ready = sel_s && tx_ready;
            if (hs_s && (g_last_s || oversize_s)) begin
               tx_abort    = oversize_s;
               state_nxt_s = ST_IFG;
            end else if (stall_to_s) begin
               tx_abort    = 1'b1;
               state_nxt_s = ST_IFG;
            end else begin
               state_nxt_s = ST_GRANT;
            end
         end
         ST_IFG: begin
            if (ifg_cnt_r == IFG_LAST) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_IFG;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   assign state_change_s = (state_nxt_s != state_r);

   // State, owner and round-robin history.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         grant_r       <= 2'b00;
         last_served_r <= 1'b1;
      end else begin
         state_r <= state_nxt_s;
         if ((state_r == ST_IDLE) && (state_nxt_s == ST_GRANT)) begin
            grant_r <= grant_pick_s;
         end else if (state_nxt_s != ST_GRANT) begin
            grant_r <= 2'b00;
         end else begin
            grant_r <= grant_r;
         end
         // Aborted frames count as served too.
         if ((state_r == ST_GRANT) && (state_nxt_s == ST_IFG)) begin
            last_served_r <= sel_s;
         end else begin
            last_served_r <= last_served_r;
         end
      end
   end

   // Frame byte counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_cnt_r <= 11'd0;
      end else if (state_change_s) begin
         byte_cnt_r <= 11'd0;
      end else if (hs_s) begin
         byte_cnt_r <= byte_cnt_r + 11'd1;
      end else begin
         byte_cnt_r <= byte_cnt_r;
      end
   end

   // Source-stall watchdog counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_r <= '0;
      end else if (state_change_s) begin
         stall_cnt_r <= '0;
      end else if ((state_r == ST_GRANT) && g_valid_s) begin
         stall_cnt_r <= '0;
      end else if ((state_r == ST_GRANT) && tx_ready) begin
         stall_cnt_r <= stall_cnt_r + STALL_W'(1);
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   // Inter-frame gap counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ifg_cnt_r <= '0;
      end else if (state_change_s) begin
         ifg_cnt_r <= '0;
      end else if (state_r == ST_IFG) begin
         ifg_cnt_r <= ifg_cnt_r + IFG_W'(1);
      end else begin
         ifg_cnt_r <= ifg_cnt_r;
      end
   end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: per-source expected-byte queues filled by
// the drivers and drained by a TX-side monitor, plus timing checks on grant/abort.
module tb_eth_tx_arbiter;

   localparam int IFG_CYCLES      = 48;
   localparam int TIMEOUT_CYCLES  = 256;
   localparam int MAX_FRAME_BYTES = 1526;
   localparam int HS_BUDGET       = 3000;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] req0_byte, req1_byte, tx_byte;
   logic       req0_valid, req0_last, req0_ready;
   logic       req1_valid, req1_last, req1_ready;
   logic       tx_valid, tx_last, tx_ready, tx_abort;
   logic [1:0] grant;

   always #5 clk = ~clk;

   eth_tx_arbiter #(
      .IFG_CYCLES      (IFG_CYCLES),
      .TIMEOUT_CYCLES  (TIMEOUT_CYCLES),
      .MAX_FRAME_BYTES (MAX_FRAME_BYTES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_byte  (req0_byte),
      .req0_valid (req0_valid),
      .req0_last  (req0_last),
      .req0_ready (req0_ready),
      .req1_byte  (req1_byte),
      .req1_valid (req1_valid),
      .req1_last  (req1_last),
      .req1_ready (req1_ready),
      .tx_byte    (tx_byte),
      .tx_valid   (tx_valid),
      .tx_last    (tx_last),
      .tx_ready   (tx_ready),
      .tx_abort   (tx_abort),
      .grant      (grant)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [1:0] grant_log[$];
   int         gap_log[$];
   int         grant_cyc_log[$];

   int         gap_cnt   = 0;
   int         abort_cnt = 0;
   int         abort_cyc = 0;
   int         fwd_cnt   = 0;
   logic       in_frame  = 1'b0;
   logic [1:0] owner     = 2'b00;
   logic [1:0] prev_grant = 2'b00;
   int         avail;
   logic [8:0] exp_b;

   int t0, t_end, f0, a0;
   bit t3_done;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // TX-side monitor: scoreboard pop, frame atomicity, ready gating, grant/gap log.
   always @(negedge clk) begin
      if (reset) begin
         in_frame   = 1'b0;
         prev_grant = 2'b00;
      end else begin
         check_eq("ready_gate", {30'd0, req1_ready & ~grant[1], req0_ready & ~grant[0]}, 32'd0);
         if (grant == 2'b01) check_eq("rdy0_mirror", req0_ready, tx_ready);
         if (grant == 2'b10) check_eq("rdy1_mirror", req1_ready, tx_ready);
         if (prev_grant == 2'b00 && grant != 2'b00) begin
            grant_log.push_back(grant);
            gap_log.push_back(gap_cnt);
            grant_cyc_log.push_back(cyc);
         end
         if (grant == 2'b00) gap_cnt++;
         if (tx_abort) begin
            abort_cnt++;
            abort_cyc = cyc;
            gap_cnt   = 0;
            in_frame  = 1'b0;
         end
         if (tx_valid && tx_ready) begin
            fwd_cnt++;
            if (!in_frame) begin
               in_frame = 1'b1;
               owner    = grant;
            end else begin
               check_eq("no_interleave", grant, owner);
            end
            if (grant == 2'b01) avail = q0.size();
            else if (grant == 2'b10) avail = q1.size();
            else avail = 0;
            check_eq("tx_has_expected", (avail > 0), 1);
            if (avail > 0) begin
               exp_b = (grant == 2'b01) ? q0.pop_front() : q1.pop_front();
               check_eq("tx_data", {23'd0, tx_last, tx_byte}, {23'd0, exp_b});
            end
            if (tx_last) begin
               in_frame = 1'b0;
               gap_cnt  = 0;
            end
         end
         prev_grant = grant;
      end
   end

   // Present one byte on a source and hold it until the arbiter accepts it.
   task automatic drive_byte(input int p, input logic [7:0] b, input logic l, input bit push);
      bit done;
      logic rdy;
      done = 1'b0;
      if (p == 0) begin
         req0_byte = b; req0_last = l; req0_valid = 1'b1;
         if (push) q0.push_back({l, b});
      end else begin
         req1_byte = b; req1_last = l; req1_valid = 1'b1;
         if (push) q1.push_back({l, b});
      end
      for (int i = 0; i < HS_BUDGET && !done; i++) begin
         @(negedge clk);
         rdy = (p == 0) ? req0_ready : req1_ready;
         if (rdy) done = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!done) check_eq("hs_timeout", 0, 1);
   endtask

   task automatic send_frame(input int p, input int len, input logic [7:0] base, input bit with_last);
      for (int k = 0; k < len; k++) begin
         drive_byte(p, base + 8'(k), with_last && (k == len - 1), 1'b1);
      end
      if (p == 0) begin
         req0_valid = 1'b0; req0_last = 1'b0;
      end else begin
         req1_valid = 1'b0; req1_last = 1'b0;
      end
   endtask

   task automatic idle_wait();
      repeat (IFG_CYCLES + 8) @(posedge clk);
      #1;
      grant_log.delete();
      gap_log.delete();
      grant_cyc_log.delete();
      f0 = fwd_cnt;
      a0 = abort_cnt;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      reset = 1'b1;
      req0_byte = 8'h00; req0_valid = 1'b0; req0_last = 1'b0;
      req1_byte = 8'h00; req1_valid = 1'b0; req1_last = 1'b0;
      tx_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("reset_outs", {9'd0, tx_valid, tx_last, tx_abort, req0_ready, req1_ready, grant, tx_byte}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Both sources contend from reset: port 0 wins the first tie, then alternate.
      grant_log.delete(); gap_log.delete(); f0 = fwd_cnt; a0 = abort_cnt;
      fork
         begin
            send_frame(0, 5, 8'h00, 1'b1);
            send_frame(0, 7, 8'h10, 1'b1);
            send_frame(0, 3, 8'h20, 1'b1);
         end
         begin
            send_frame(1, 4, 8'h80, 1'b1);
            send_frame(1, 6, 8'h90, 1'b1);
            send_frame(1, 8, 8'hA0, 1'b1);
         end
      join
      repeat (2) @(posedge clk);
      #1;
      check_eq("rr_count", grant_log.size(), 6);
      for (int i = 0; i < 6; i++) begin
         check_eq("rr_order", grant_log[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      // Pending request: 48 gap clocks plus the IDLE arbitration clock.
      for (int i = 1; i < 6; i++) check_eq("rr_gap", gap_log[i], IFG_CYCLES + 1);
      check_eq("rr_fwd", fwd_cnt - f0, 33);
      check_eq("rr_q0", q0.size(), 0);
      check_eq("rr_q1", q1.size(), 0);
      check_eq("rr_abort", abort_cnt - a0, 0);

      // Single source, 60-byte frame followed by a short frame.
      idle_wait();
      t0 = cyc;
      send_frame(0, 60, 8'h40, 1'b1);
      send_frame(0, 4, 8'hF0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      check_eq("t1_grants", grant_log.size(), 2);
      check_eq("t1_grant0", grant_log[0], 2'b01);
      check_eq("t1_latency", grant_cyc_log[0] - t0, 1);
      check_eq("t1_gap", gap_log[1], IFG_CYCLES + 1);
      check_eq("t1_fwd", fwd_cnt - f0, 64);
      check_eq("t1_q0", q0.size(), 0);

      // Port 1 frame with tx_ready toggling every clock.
      idle_wait();
      t3_done = 1'b0;
      fork
         begin
            send_frame(1, 12, 8'hB0, 1'b1);
            t3_done = 1'b1;
         end
         begin
            while (!t3_done) begin
               @(posedge clk);
               #1;
               tx_ready = ~tx_ready;
            end
         end
      join
      tx_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("t3_grant", grant_log[0], 2'b10);
      check_eq("t3_fwd", fwd_cnt - f0, 12);
      check_eq("t3_q1", q1.size(), 0);
      check_eq("t3_abort", abort_cnt - a0, 0);

      // Port 0 stalls mid-frame; port 1 request waits through the abort and gap.
      idle_wait();
      for (int k = 0; k < 10; k++) drive_byte(0, 8'h30 + 8'(k), 1'b0, 1'b1);
      t_end = cyc;
      req0_valid = 1'b0;
      send_frame(1, 6, 8'hC0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      check_eq("t4_abort_cnt", abort_cnt - a0, 1);
      check_eq("t4_abort_cyc", abort_cyc - t_end, TIMEOUT_CYCLES - 1);
      check_eq("t4_grants", grant_log.size(), 2);
      check_eq("t4_grant1", grant_log[1], 2'b10);
      check_eq("t4_gap", gap_log[1], IFG_CYCLES + 1);
      check_eq("t4_q0", q0.size(), 0);
      check_eq("t4_q1", q1.size(), 0);

      // Oversize: byte MAX_FRAME_BYTES+1 without last is swallowed and aborts.
      idle_wait();
      for (int k = 0; k < MAX_FRAME_BYTES; k++) drive_byte(1, 8'(k), 1'b0, 1'b1);
      req1_byte = 8'hEE;
      req1_last = 1'b0;
      @(negedge clk);
      check_eq("t5_ready", req1_ready, 1'b1);
      check_eq("t5_tx_valid", tx_valid, 1'b0);
      check_eq("t5_abort", tx_abort, 1'b1);
      @(posedge clk);
      #1;
      req1_valid = 1'b0;
      @(negedge clk);
      check_eq("t5_ifg_grant", grant, 2'b00);
      check_eq("t5_ifg_ready", req1_ready, 1'b0);
      check_eq("t5_abort_cnt", abort_cnt - a0, 1);
      check_eq("t5_fwd", fwd_cnt - f0, MAX_FRAME_BYTES);
      check_eq("t5_q1", q1.size(), 0);
      @(posedge clk);
      #1;

      // Reset in the middle of a port 0 frame.
      idle_wait();
      for (int k = 0; k < 19; k++) drive_byte(0, 8'h50 + 8'(k), 1'b0, 1'b1);
      req0_byte = 8'h77;
      #2;
      reset = 1'b1;
      #1;
      check_eq("t6_rst_outs", {9'd0, tx_valid, tx_last, tx_abort, req0_ready, req1_ready, grant, tx_byte}, 32'd0);
      req0_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_eq("t6_abort_cnt", abort_cnt - a0, 0);
      check_eq("t6_q0", q0.size(), 0);
      grant_log.delete();
      fork
         send_frame(0, 3, 8'h01, 1'b1);
         send_frame(1, 3, 8'h81, 1'b1);
      join
      repeat (2) @(posedge clk);
      #1;
      check_eq("t6_first", grant_log[0], 2'b01);
      check_eq("t6_second", grant_log[1], 2'b10);
      check_eq("t6_q0_end", q0.size(), 0);
      check_eq("t6_q1_end", q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Frame-atomic arbiter that shares the single byte-serial Ethernet TX path between two frame sources: port 0 for ARP/ICMP replies, port 1 for UDP payload frames.
- Sits between the frame builders and the RMII transmitter. Both sides run on the 50 MHz PHY clock.
- Enforces round-robin fairness, inter-frame gap (IFG), a stall watchdog and a maximum frame length. A frame is never interleaved with another.

Parameters:
- IFG_CYCLES, 48: idle clocks after each frame (12 byte-times x 4 clocks per byte at RMII 100 Mb/s).
- TIMEOUT_CYCLES, 256: consecutive clocks the granted source may hold valid low mid-frame before the frame is aborted.
- MAX_FRAME_BYTES, 1526: maximum bytes per frame (preamble/SFD + 1518). The byte that would exceed this aborts the frame.

Ports:
- clk  in  1  50 MHz PHY clock
- reset  in  1  asynchronous, active-high reset
- req0_byte  in  8  source 0 data byte
- req0_valid  in  1  source 0 byte valid; first valid while idle is a request
- req0_last  in  1  source 0 final byte of frame, qualified by req0_valid
- req0_ready  out  1  source 0 byte accepted this cycle when valid&ready
- req1_byte  in  8  source 1 data byte
- req1_valid  in  1  source 1 byte valid / request
- req1_last  in  1  source 1 final byte of frame
- req1_ready  out  1  source 1 accept
- tx_byte  out  8  byte to RMII transmitter
- tx_valid  out  1  tx_byte valid
- tx_last  out  1  final byte of frame
- tx_ready  in  1  transmitter accepts byte when tx_valid&tx_ready
- tx_abort  out  1  one-cycle pulse: current frame truncated, transmitter must discard it
- grant  out  2  one-hot owner of TX path; 00 when none

Behaviour:
- Reset (async, active-high): state IDLE, grant=00, last_served=1 (so source 0 wins the first tie), all counters 0. Outputs: tx_valid=0, tx_last=0, tx_byte=0, tx_abort=0, req0_ready=0, req1_ready=0. Reset mid-frame drops the frame silently, with no abort pulse.
- Transfer rule: a byte moves only when valid and ready are both high in the same cycle.
- FSM states: IDLE, GRANT, IFG.
- IDLE:
  - grant=00, all ready=0.
  - If exactly one reqN_valid is high, register grant to that source.
  - If both are high, grant the source != last_served.
  - Move to GRANT on the next edge. Grant latency is 1 clock after the request is seen.
- GRANT:
  - tx_byte, tx_valid and tx_last are combinational muxes of the granted source.
  - Granted reqN_ready = tx_ready. The non-granted ready is held 0.
  - grant is held stable for the whole frame.
- GRANT, frame counting:
  - byte_cnt increments on each handshake.
  - On a handshake with last=1: last_served <= granted index, go to IFG.
- GRANT, stall watchdog:
  - stall_cnt increments each cycle the granted valid is low and clears on granted valid high.
  - When stall_cnt reaches TIMEOUT_CYCLES-1 with valid still low: pulse tx_abort, go to IFG.
- GRANT, oversize frame:
  - A handshake with byte_cnt == MAX_FRAME_BYTES and last=0 is accepted. The byte is not forwarded as valid: tx_valid is forced 0 that cycle.
  - tx_abort pulses and the FSM goes to IFG.
  - The granted source's remaining bytes are its own responsibility; the arbiter keeps ready=0 to it in IFG.
- Aborted frames still update last_served.
- IFG:
  - grant=00, all ready=0, tx_valid=0.
  - ifg_cnt counts 0..IFG_CYCLES-1, then returns to IDLE. Arbitration happens in IDLE on the following cycle.
  - Requests arriving during IFG wait. Their valid/byte must stay stable.
- tx_ready low in GRANT does not advance stall_cnt. The watchdog measures source stall only.
- Counters: byte_cnt is 11 bits, ifg_cnt and stall_cnt are sized by $clog2 of their parameter. All clear on entry to GRANT and IFG.

Test Plan:
- Only req0 sends a 60-byte frame with tx_ready=1 -> grant=01 one clock after valid; 60 tx handshakes; tx_last on byte 60; grant=00 for exactly 48 clocks; req1_ready=0 throughout.
- req0 and req1 both valid at the same edge, each sending 3 frames -> grant order 01,10,01,10,01,10; no byte of one frame appears inside another frame.
- req1 frame with tx_ready toggling 1,0,1,0 -> each byte forwarded exactly once; req1_ready mirrors tx_ready; no abort.
- req0 sends 10 bytes, then drops valid for 256 clocks -> tx_abort one pulse at stall clock 256; IFG follows; a later req1 frame is granted normally.
- req1 sends 1527 bytes without last -> byte 1527 is accepted with tx_valid=0; tx_abort pulses that cycle; FSM enters IFG.
- Assert reset at byte 20 of a req0 frame -> all outputs 0 immediately with no tx_abort; after release, req0 and req1 valid together -> req0 granted first.
